// File: rtl/bram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter_if
// Description : Requester-side handshake and RAM-port bundle for the shared
//               block-RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    // requester beats
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0]            req_we_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    // read responses
    logic [NUM_REQ-1:0]            rsp_valid_o;
    logic [DATA_WIDTH-1:0]         rsp_data_o;
    // RAM port
    logic                          bram_en_o;
    logic                          bram_we_o;
    logic [ADDR_WIDTH-1:0]         bram_addr_o;
    logic [DATA_WIDTH-1:0]         bram_din_o;
    logic [DATA_WIDTH-1:0]         bram_dout_i;

    // arbiter view
    modport slave (
        input  req_valid_i, req_we_i, req_last_i, req_addr_i, req_data_i, bram_dout_i,
        output req_ready_o, rsp_valid_o, rsp_data_o,
               bram_en_o, bram_we_o, bram_addr_o, bram_din_o
    );

    // requester/RAM environment view
    modport master (
        output req_valid_i, req_we_i, req_last_i, req_addr_i, req_data_i, bram_dout_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o,
               bram_en_o, bram_we_o, bram_addr_o, bram_din_o
    );
endinterface
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Round-robin arbiter sharing one block-RAM port between
//               NUM_REQ requesters, with burst locking and one-cycle read
//               return to the issuing requester.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    bram_port_arbiter_if.slave   bus
);

    localparam int                  c_IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);
    localparam logic [0:0]          c_ST_IDLE   = 1'b0;
    localparam logic [0:0]          c_ST_LOCKED = 1'b1;

    logic [0:0]            r_state;
    logic [c_IDX_W-1:0]    r_owner;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic                  r_rd_pend;
    logic [c_IDX_W-1:0]    r_rd_id;

    logic                  w_accept;
    logic [c_IDX_W-1:0]    w_grant;
    logic [c_IDX_W-1:0]    w_next_idx;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_we;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic [NUM_REQ-1:0]    w_rsp_valid;

    // Pick the granted requester: the owner while locked, otherwise the first
    // valid requester scanning circularly from the round-robin pointer.
    always_comb begin : p_arbitrate
        logic [c_IDX_W-1:0] w_cand;
        w_cand   = '0;
        w_grant  = '0;
        w_accept = 1'b0;
        if (r_state == c_ST_LOCKED) begin
            w_grant  = r_owner;
            w_accept = bus.req_valid_i[r_owner];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_cand = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                if (!w_accept && bus.req_valid_i[w_cand]) begin
                    w_accept = 1'b1;
                    w_grant  = w_cand;
                end
            end
        end
        // nothing is accepted while reset is held
        w_accept = w_accept & rstn_i;
    end

    // One-hot ready and the accepted beat's fields; an OR-mux over the one-hot
    // ready leaves address and data at zero when nothing is accepted.
    always_comb begin : p_beat_mux
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_grant] = 1'b1;
        end
        w_addr = '0;
        w_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ready[i]) begin
                w_addr = w_addr | bus.req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_din  = w_din  | bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        w_we       = |(w_ready & bus.req_we_i);
        w_last     = |(w_ready & bus.req_last_i);
        w_next_idx = (w_grant == c_LAST_IDX) ? '0 : w_grant + 1'b1;
    end

    // Route the registered RAM output to the requester that issued the read;
    // reset masks a response that would otherwise land in a reset cycle.
    always_comb begin : p_response
        w_rsp_valid = '0;
        if (r_rd_pend && rstn_i) begin
            w_rsp_valid[r_rd_id] = 1'b1;
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.bram_en_o   = w_accept;
    assign bus.bram_we_o   = w_accept & w_we;
    assign bus.bram_addr_o = w_addr;
    assign bus.bram_din_o  = w_din;
    assign bus.rsp_valid_o = w_rsp_valid;
    assign bus.rsp_data_o  = (r_rd_pend && rstn_i) ? bus.bram_dout_i : '0;

    // Lock FSM, round-robin pointer and pending-read tracking.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state   <= c_ST_IDLE;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_rd_pend <= 1'b0;
            r_rd_id   <= '0;
        end else begin
            r_rd_pend <= w_accept & ~w_we;
            if (w_accept) begin
                r_rd_id <= w_grant;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_rr_ptr <= w_next_idx;
                        if (!w_last) begin
                            r_owner <= w_grant;
                            r_state <= c_ST_LOCKED;
                        end
                    end
                end
                c_ST_LOCKED: begin
                    // w_grant equals the owner here, so w_next_idx is owner+1
                    if (w_accept && w_last) begin
                        r_state  <= c_ST_IDLE;
                        r_rr_ptr <= w_next_idx;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Self-checking bench for bram_port_arbiter: vector table,
//               directed multi-cycle sequences and a randomized stream checked
//               against a behavioural arbiter/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int AW      = 8;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    bram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_port_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    // registered-output RAM behind the arbitrated port
    logic [DW-1:0] ram [0:255];
    always @(posedge clk_i) begin
        if (bus.bram_en_o) begin
            if (bus.bram_we_o) ram[bus.bram_addr_o] <= bus.bram_din_o;
            else               bus.bram_dout_i      <= ram[bus.bram_addr_o];
        end
    end

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] a_addr [NUM_REQ];
    logic [DW-1:0] a_data [NUM_REQ];

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] we, input logic [3:0] last);
        bus.req_valid_i = v;
        bus.req_we_i    = we;
        bus.req_last_i  = last;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_addr_i[i*AW +: AW] = a_addr[i];
            bus.req_data_i[i*DW +: DW] = a_data[i];
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // apply one beat pattern, check ready, then advance one clock
    task automatic cyc(input string nm, input logic [3:0] v, input logic [3:0] we,
                       input logic [3:0] last, input logic [3:0] exp_ready);
        drive(v, we, last);
        #1;
        check(nm, bus.req_ready_o, exp_ready);
        tick();
    endtask

    task automatic reset_dut();
        rstn_i = 1'b0;
        drive(4'h0, 4'h0, 4'h0);
        tick();
        tick();
        rstn_i = 1'b1;
    endtask

    // random-phase state
    logic [DW-1:0] m_mem   [256];
    bit            m_known [256];
    bit            pv   [NUM_REQ];
    bit            pwe  [NUM_REQ];
    bit            plast[NUM_REQ];
    int            left [NUM_REQ];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // {valid, expected ready, expected rsp_valid from previous read}
        tbl[0]  = '{4'b1111, 4'b0001, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0010, 4'b0001};
        tbl[2]  = '{4'b1111, 4'b0100, 4'b0010};
        tbl[3]  = '{4'b1111, 4'b1000, 4'b0100};
        tbl[4]  = '{4'b1111, 4'b0001, 4'b1000};
        tbl[5]  = '{4'b1111, 4'b0010, 4'b0001};
        tbl[6]  = '{4'b1001, 4'b1000, 4'b0010};
        tbl[7]  = '{4'b0110, 4'b0010, 4'b1000};
        tbl[8]  = '{4'b0001, 4'b0001, 4'b0010};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0001};
        tbl[10] = '{4'b0101, 4'b0100, 4'b0000};
        tbl[11] = '{4'b0011, 4'b0001, 4'b0100};

        for (int i = 0; i < NUM_REQ; i++) begin
            a_addr[i] = AW'(8'h20 + i);
            a_data[i] = DW'(32'h1000 + i);
        end
        bus.req_valid_i = '0;
        bus.req_we_i    = '0;
        bus.req_last_i  = '0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;

        // ---- reset held with every requester valid ----
        rstn_i = 1'b0;
        drive(4'b1111, 4'b0000, 4'b1111);
        repeat (3) begin
            tick();
            check("rst_ready", bus.req_ready_o, 4'b0000);
            check("rst_rsp_valid", bus.rsp_valid_o, 4'b0000);
            check("rst_bram_en", bus.bram_en_o, 1'b0);
            check("rst_rsp_data", bus.rsp_data_o, 32'h0);
        end
        rstn_i = 1'b1;

        // ---- vector table: round-robin single-beat reads ----
        for (int t = 0; t < 12; t++) begin
            drive(tbl[t].valid, 4'b0000, 4'b1111);
            #1;
            check($sformatf("tbl%0d_ready", t), bus.req_ready_o, tbl[t].exp_ready);
            check($sformatf("tbl%0d_en", t), bus.bram_en_o, |tbl[t].exp_ready);
            check($sformatf("tbl%0d_rsp", t), bus.rsp_valid_o, tbl[t].exp_rsp);
            tick();
        end

        // ---- read return: write from req 2, read back from req 1 ----
        a_addr[2] = 8'h10;
        a_data[2] = 32'hDEADBEEF;
        drive(4'b0100, 4'b0100, 4'b1111);
        #1;
        check("rr_wr_ready", bus.req_ready_o, 4'b0100);
        check("rr_wr_we", bus.bram_we_o, 1'b1);
        check("rr_wr_addr", bus.bram_addr_o, 8'h10);
        tick();
        a_addr[1] = 8'h10;
        cyc("rr_rd_ready", 4'b0010, 4'b0000, 4'b1111, 4'b0010);
        drive(4'b0000, 4'b0000, 4'b0000);
        #1;
        check("rr_rsp_valid", bus.rsp_valid_o, 4'b0010);
        check("rr_rsp_data", bus.rsp_data_o, 32'hDEADBEEF);
        check("idle_addr_zero", bus.bram_addr_o, 8'h00);
        tick();

        // ---- burst lock by req 1 with a two-cycle bubble ----
        reset_dut();
        cyc("bl_beat1", 4'b0010, 4'b0010, 4'b0000, 4'b0010);
        cyc("bl_beat2", 4'b1011, 4'b0010, 4'b1001, 4'b0010);
        cyc("bl_bubble1", 4'b1001, 4'b0010, 4'b1001, 4'b0000);
        cyc("bl_bubble2", 4'b1001, 4'b0010, 4'b1001, 4'b0000);
        cyc("bl_beat3", 4'b1011, 4'b0010, 4'b1001, 4'b0010);
        cyc("bl_beat4", 4'b1011, 4'b0010, 4'b1011, 4'b0010);
        cyc("bl_after", 4'b1001, 4'b0000, 4'b1001, 4'b1000);

        // ---- reset in the middle of a req 3 burst ----
        reset_dut();
        cyc("rm_beat1", 4'b1000, 4'b1000, 4'b0000, 4'b1000);
        cyc("rm_beat2_rd", 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        rstn_i = 1'b0;
        drive(4'b1111, 4'b0000, 4'b1111);
        #1;
        check("rm_rsp_valid", bus.rsp_valid_o, 4'b0000);
        check("rm_rsp_data", bus.rsp_data_o, 32'h0);
        check("rm_ready", bus.req_ready_o, 4'b0000);
        tick();
        rstn_i = 1'b1;
        #1;
        check("rm_release_ready", bus.req_ready_o, 4'b0001);
        check("rm_release_rsp", bus.rsp_valid_o, 4'b0000);
        tick();

        // ---- randomized mixed stream against a behavioural model ----
        reset_dut();
        begin
            int  beats     = 0;
            int  cycles    = 0;
            bit  m_locked  = 0;
            int  m_owner   = 0;
            int  m_rr      = 0;
            logic [3:0] exp_rsp_v = '0;
            logic [DW-1:0] exp_rsp_d = '0;
            bit  exp_rsp_k = 0;
            for (int i = 0; i < 256; i++) m_known[i] = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                pv[i] = 0; left[i] = 0;
            end
            while (beats < 1000 && cycles < 20000) begin
                int g;
                logic [3:0] v_bits, we_bits, last_bits, exp_ready;
                cycles++;
                // requester behaviour: hold valid until accepted
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!pv[i]) begin
                        if (left[i] == 0 && $urandom_range(0, 1) == 1)
                            left[i] = $urandom_range(1, 4);
                        if (left[i] > 0 && $urandom_range(0, 9) < 7) begin
                            pv[i]     = 1;
                            pwe[i]    = $urandom_range(0, 1) == 1;
                            plast[i]  = (left[i] == 1);
                            a_addr[i] = AW'(8'h80 + $urandom_range(0, 15));
                            a_data[i] = $urandom;
                        end
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    v_bits[i]    = pv[i];
                    we_bits[i]   = pwe[i];
                    last_bits[i] = plast[i];
                end
                drive(v_bits, we_bits, last_bits);
                #1;
                // expected grant from the arbitration rules
                g = -1;
                if (m_locked) begin
                    if (pv[m_owner]) g = m_owner;
                end else begin
                    for (int k = 0; k < NUM_REQ; k++)
                        if (g < 0 && pv[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
                end
                exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
                check("rnd_ready", bus.req_ready_o, exp_ready);
                check("rnd_onehot", ($countones(bus.req_ready_o) <= 1), 1'b1);
                check("rnd_en", bus.bram_en_o, g >= 0);
                if (g >= 0) begin
                    check("rnd_we", bus.bram_we_o, pwe[g]);
                    check("rnd_addr", bus.bram_addr_o, a_addr[g]);
                    check("rnd_din", bus.bram_din_o, a_data[g]);
                end
                check("rnd_rsp_valid", bus.rsp_valid_o, exp_rsp_v);
                if (exp_rsp_v != 0 && exp_rsp_k)
                    check("rnd_rsp_data", bus.rsp_data_o, exp_rsp_d);
                // advance the model
                exp_rsp_v = '0;
                if (g >= 0) begin
                    beats++;
                    if (pwe[g]) begin
                        m_mem[a_addr[g]]   = a_data[g];
                        m_known[a_addr[g]] = 1;
                    end else begin
                        exp_rsp_v = 4'(1 << g);
                        exp_rsp_d = m_mem[a_addr[g]];
                        exp_rsp_k = m_known[a_addr[g]];
                    end
                    if (m_locked) begin
                        if (plast[g]) begin
                            m_locked = 0;
                            m_rr     = (g + 1) % NUM_REQ;
                        end
                    end else begin
                        m_rr = (g + 1) % NUM_REQ;
                        if (!plast[g]) begin
                            m_locked = 1;
                            m_owner  = g;
                        end
                    end
                    pv[g]   = 0;
                    left[g] = left[g] - 1;
                end
                tick();
            end
            check("rnd_beats_done", beats >= 1000, 1'b1);
            drive(4'b0000, 4'b0000, 4'b0000);
            #1;
            check("rnd_final_rsp", bus.rsp_valid_o, exp_rsp_v);
            if (exp_rsp_v != 0 && exp_rsp_k)
                check("rnd_final_data", bus.rsp_data_o, exp_rsp_d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
